// File: rtl/ladybird_ibus_ram_subsystem.sv
// Instruction-side memory: fixed-priority N-master arbiter in front of a single-port,
// byte-strobed word RAM with a one-cycle registered read response.
module ladybird_ibus_ram_subsystem #(
  parameter int N_INPUT = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 3,
  parameter int BUS_AW  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_INPUT-1:0]           m_req,
  output logic [N_INPUT-1:0]           m_gnt,
  input  logic [N_INPUT*BUS_AW-1:0]    m_addr,
  input  logic [N_INPUT*(DATA_W/8)-1:0] m_wstrb,
  input  logic [N_INPUT*DATA_W-1:0]    m_wdata,
  output logic [N_INPUT-1:0]           m_rvalid,
  output logic [DATA_W-1:0]            m_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [N_INPUT-1:0] gnt_s;
  logic               any_s;
  logic [ADDR_W-1:0]  idx_s;
  logic [NB-1:0]      wstrb_s;
  logic [DATA_W-1:0]  wdata_s;
  logic               wr_s;
  logic               rd_s;

  logic [DATA_W-1:0]  mem_r [DEPTH];
  logic [N_INPUT-1:0] rvalid_r;
  logic [DATA_W-1:0]  rdata_r;

  // Only the word-index bits of each address matter; the rest alias away.
  logic unused_addr_s;
  assign unused_addr_s = ^m_addr;

  // Fixed-priority select and request mux; scanning downward lets the lowest index win.
  always_comb begin
    gnt_s   = '0;
    any_s   = 1'b0;
    idx_s   = '0;
    wstrb_s = '0;
    wdata_s = '0;
    for (int i = N_INPUT - 1; i >= 0; i--) begin
      if (m_req[i]) begin
        gnt_s    = '0;
        gnt_s[i] = 1'b1;
        any_s    = 1'b1;
        idx_s    = m_addr[i*BUS_AW+2 +: ADDR_W];
        wstrb_s  = m_wstrb[i*NB +: NB];
        wdata_s  = m_wdata[i*DATA_W +: DATA_W];
      end else begin
        gnt_s[i] = 1'b0;
      end
    end
  end

  assign wr_s  = |wstrb_s;
  assign rd_s  = any_s & ~wr_s;
  assign m_gnt = gnt_s;

  // Byte-lane RAM write; deliberately unaffected by rst so the image survives a core reset.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb_s[b]) begin
          mem_r[idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
        end
      end
    end
  end

  // Response register, reloaded every cycle: one-hot valid plus data after a read, zeros otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_r <= '0;
      rdata_r  <= '0;
    end else if (rd_s) begin
      rvalid_r <= gnt_s;
      rdata_r  <= mem_r[idx_s];
    end else begin
      rvalid_r <= '0;
      rdata_r  <= '0;
    end
  end

  assign m_rvalid = rvalid_r;
  assign m_rdata  = rdata_r;

endmodule

// File: tb/tb_ladybird_ibus_ram_subsystem.sv
// Scoreboard bench for ladybird_ibus_ram_subsystem: a reference memory and priority model
// push the expected response each cycle; it is popped and compared one edge later.
module tb_ladybird_ibus_ram_subsystem;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_req;
  logic [1:0]  m_gnt;
  logic [63:0] m_addr;
  logic [7:0]  m_wstrb;
  logic [63:0] m_wdata;
  logic [1:0]  m_rvalid;
  logic [31:0] m_rdata;

  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [3:0]  wstrb_v [2];

  assign m_addr  = {addr_v[1], addr_v[0]};
  assign m_wdata = {wdata_v[1], wdata_v[0]};
  assign m_wstrb = {wstrb_v[1], wstrb_v[0]};

  typedef struct packed {
    logic [1:0]  v;
    logic [31:0] d;
  } rsp_t;

  rsp_t        sb_q [$];
  logic [31:0] model_mem [8];
  int          n_checks = 0;
  int          n_errors = 0;

  ladybird_ibus_ram_subsystem dut (
    .clk      (clk),
    .rst      (rst),
    .m_req    (m_req),
    .m_gnt    (m_gnt),
    .m_addr   (m_addr),
    .m_wstrb  (m_wstrb),
    .m_wdata  (m_wdata),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_idle();
    m_req = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr_v[i]  = 32'h0;
      wdata_v[i] = 32'h0;
      wstrb_v[i] = 4'h0;
    end
  endtask

  task automatic rd(input int m, input logic [31:0] a);
    set_idle();
    m_req[m]  = 1'b1;
    addr_v[m] = a;
  endtask

  task automatic wr(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    set_idle();
    m_req[m]   = 1'b1;
    addr_v[m]  = a;
    wdata_v[m] = d;
    wstrb_v[m] = s;
  endtask

  // One bus cycle: check the grant, predict the response, advance, compare the response.
  task automatic step(input string tag);
    rsp_t       e;
    logic [1:0] eg;
    int         s;
    logic [2:0] idx;
    #1;
    eg = m_req[0] ? 2'b01 : (m_req[1] ? 2'b10 : 2'b00);
    s  = m_req[0] ? 0 : 1;
    check({tag, ".gnt"}, {30'h0, m_gnt}, {30'h0, eg});
    idx = addr_v[s][4:2];
    e   = '0;
    if (eg != 2'b00 && wstrb_v[s] == 4'h0 && !rst) begin
      e.v = eg;
      e.d = model_mem[idx];
    end
    if (eg != 2'b00 && wstrb_v[s] != 4'h0) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_v[s][b]) model_mem[idx][8*b +: 8] = wdata_v[s][8*b +: 8];
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".rvalid"}, {30'h0, m_rvalid}, {30'h0, e.v});
    check({tag, ".rdata"}, m_rdata, e.d);
  endtask

  logic [31:0] prog [5];

  initial begin
    prog[0] = 32'hfff00093;
    prog[1] = 32'hfff08103;
    prog[2] = 32'h00110113;
    prog[3] = 32'h00208023;
    prog[4] = 32'hff5ff06f;

    rst = 1'b1;
    set_idle();
    @(posedge clk);
    #1;
    check("reset.rvalid", {30'h0, m_rvalid}, 32'h0);
    check("reset.rdata", m_rdata, 32'h0);

    // Read granted while in reset is discarded.
    rd(1, 32'h0);
    step("reset_rd");
    rst = 1'b0;

    // Program load by master 0, fetch by master 1.
    for (int i = 0; i < 5; i++) begin
      wr(0, 32'(i * 4), prog[i], 4'hf);
      step("load");
    end
    for (int i = 0; i < 5; i++) begin
      rd(1, 32'(i * 4));
      step("fetch");
      check("fetch.word", m_rdata, prog[i]);
    end

    // Contention: master 0 wins while both request.
    set_idle();
    m_req     = 2'b11;
    addr_v[0] = 32'h0000_0004;
    addr_v[1] = 32'h0000_0010;
    for (int i = 0; i < 3; i++) step("contend");
    m_req[0] = 1'b0;
    step("contend_drop");

    // Byte strobes.
    wr(0, 32'h08, 32'h11223344, 4'hf);  step("strb_w0");
    wr(0, 32'h08, 32'h000000AB, 4'b0001); step("strb_w1");
    wr(1, 32'h08, 32'hCD000000, 4'b1000); step("strb_w2");
    rd(1, 32'h08);                        step("strb_rd");
    check("strb.word", m_rdata, 32'hCD2233AB);

    // Aliasing modulo 32 bytes, low two bits ignored.
    wr(0, 32'h20, 32'hDEADBEEF, 4'hf); step("alias_w");
    rd(1, 32'h00);                     step("alias_rd0");
    check("alias.rd0", m_rdata, 32'hDEADBEEF);
    rd(0, 32'h03);                     step("alias_rd3");
    check("alias.rd3", m_rdata, 32'hDEADBEEF);

    // Pipelined reads from different masters, then idle.
    rd(1, 32'h04); step("pipe_m1");
    check("pipe.m1", m_rdata, prog[1]);
    rd(0, 32'h0C); step("pipe_m0");
    check("pipe.m0", m_rdata, prog[3]);
    set_idle();    step("pipe_idle");

    // Read just before reset still answers; read in reset does not; writes in reset land.
    rd(1, 32'h04); step("pre_rst_rd");
    rst = 1'b1;
    rd(1, 32'h0C); step("rst_rd");
    wr(0, 32'h1C, 32'h5A5A5A5A, 4'hf); step("rst_wr");
    rst = 1'b0;
    rd(1, 32'h08); step("post_rst_rd");
    check("post_rst.word", m_rdata, 32'hCD2233AB);
    rd(1, 32'h1C); step("post_rst_rd2");
    check("post_rst.rstwr", m_rdata, 32'h5A5A5A5A);

    // Fill the remaining words, then mixed random traffic.
    wr(0, 32'h14, 32'h01010101, 4'hf); step("fill");
    wr(0, 32'h18, 32'h02020202, 4'hf); step("fill");
    for (int n = 0; n < 60; n++) begin
      m_req = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        addr_v[i]  = $urandom;
        wdata_v[i] = $urandom;
        wstrb_v[i] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      step("rand");
    end
    set_idle();
    step("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
